// File: rtl/fmap_bank_sram_pkg.sv
// Shared widths and helpers for the banked feature-map SRAM and its per-bank arbiter.
package fmap_bank_sram_pkg;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = '1;

  // Index width that stays legal when only one item exists.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned fmem_addr_w(input int unsigned nbank, input int unsigned bank_aw);
    return idx_w(nbank) + bank_aw;
  endfunction

endpackage

// File: rtl/fmap_bank_arb.sv
// Per-bank arbiter: round-robin among reads, write has priority until the read side
// has been denied STARVE_MAX consecutive cycles.
module fmap_bank_arb
  import fmap_bank_sram_pkg::*;
#(
  parameter int unsigned NRP        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NRP-1:0] rd_req_i,
  input  logic           wr_req_i,
  output logic [NRP-1:0] rd_gnt_o,
  output logic           wr_gnt_o
);

  localparam int unsigned PW = idx_w(NRP);
  localparam int unsigned SW = idx_w(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel, cand;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_any, rd_win, found;

  always_comb begin
    rd_any   = rst_n && (|rd_req_i);
    rd_win   = rd_any && (!wr_req_i || (starve_q == STARVE_LIM));
    wr_gnt_o = rst_n && wr_req_i && !rd_win;

    sel   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NRP; k++) begin
      cand = PW'((32'(ptr_q) + k) % NRP);
      if (!found && rd_req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end

    rd_gnt_o = '0;
    if (rd_win) begin
      rd_gnt_o[sel] = 1'b1;
    end

    ptr_d = ptr_q;
    if (rd_win) begin
      ptr_d = PW'((32'(sel) + 32'd1) % NRP);
    end

    // Only a write-induced denial builds up starvation.
    starve_d = starve_q;
    if (!rd_any || rd_win) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      starve_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/fmap_bank_sram.sv
// Banked feature-map SRAM: NBANK single-port banks, NRP read ports, one write port.
// Define FMAP_RDATA_REG_EN to add an output register stage (read latency 2 instead of 1).
module fmap_bank_sram
  import fmap_bank_sram_pkg::*;
#(
  parameter  int unsigned DATA_W     = 64,
  parameter  int unsigned BANK_AW    = 10,
  parameter  int unsigned NBANK      = 2,
  parameter  int unsigned NRP        = 2,
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned BSEL_W     = idx_w(NBANK),
  localparam int unsigned AW         = fmem_addr_w(NBANK, BANK_AW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRP-1:0]        rreq,
  input  logic [NRP*AW-1:0]     raddr,
  output logic [NRP-1:0]        rgnt,
  output logic [NRP-1:0]        rvalid,
  output logic [NRP*DATA_W-1:0] rdata,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  wready,
  input  logic                  stat_clr,
  output logic [STAT_W-1:0]     stall_cnt
);

  logic [NRP-1:0][AW-1:0]       raddr_a;
  logic [NRP-1:0][BSEL_W-1:0]   rbank;
  logic [BSEL_W-1:0]            wbank;
  logic [NBANK-1:0][NRP-1:0]    bank_rreq, bank_rgnt;
  logic [NBANK-1:0]             bank_wreq, bank_wgnt;
  logic [NBANK-1:0][DATA_W-1:0] bank_rd;

  assign raddr_a = raddr;
  assign wbank   = waddr[AW-1 -: BSEL_W];

  // rreq gates every decode term so an idle port's address is never looked at.
  always_comb begin
    rbank     = '0;
    bank_rreq = '0;
    bank_wreq = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      rbank[p] = raddr_a[p][AW-1 -: BSEL_W];
    end
    for (int unsigned b = 0; b < NBANK; b++) begin
      bank_wreq[b] = wen && (wbank == BSEL_W'(b));
      for (int unsigned p = 0; p < NRP; p++) begin
        bank_rreq[b][p] = rreq[p] && (rbank[p] == BSEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [BANK_AW-1:0] ad;
    logic [DATA_W-1:0]  mem [2**BANK_AW];
    logic [DATA_W-1:0]  rd_q;
    logic [NRP-1:0]     gnt;
    logic               wgnt;

    fmap_bank_arb #(
      .NRP        (NRP),
      .STARVE_MAX (STARVE_MAX)
    ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_req_i (bank_rreq[b]),
      .wr_req_i (bank_wreq[b]),
      .rd_gnt_o (gnt),
      .wr_gnt_o (wgnt)
    );

    always_comb begin
      ad = waddr[BANK_AW-1:0];
      for (int unsigned p = 0; p < NRP; p++) begin
        if (gnt[p]) begin
          ad = raddr_a[p][BANK_AW-1:0];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (wgnt) begin
        mem[ad] <= wd;
      end else if (|gnt) begin
        rd_q <= mem[ad];
      end
    end

    assign bank_rgnt[b] = gnt;
    assign bank_wgnt[b] = wgnt;
    assign bank_rd[b]   = rd_q;
  end

  always_comb begin
    rgnt = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      rgnt = rgnt | bank_rgnt[b];
    end
  end

  assign wready = |bank_wgnt;

  // Read return path: the bank tag remembers where each port's word will appear.
  logic [NRP-1:0]               rv_q;
  logic [NRP-1:0][BSEL_W-1:0]   tag_q;
  logic [NRP-1:0][DATA_W-1:0]   out_q;
  logic [NRP-1:0][DATA_W-1:0]   rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      rd_mux[p] = bank_rd[tag_q[p]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q  <= '0;
      tag_q <= '0;
      out_q <= '0;
    end else begin
      rv_q <= rgnt;
      for (int unsigned p = 0; p < NRP; p++) begin
        if (rgnt[p]) begin
          tag_q[p] <= rbank[p];
        end
        if (rv_q[p]) begin
          out_q[p] <= rd_mux[p];
        end
      end
    end
  end

`ifdef FMAP_RDATA_REG_EN
  logic [NRP-1:0] rv2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv2_q <= '0;
    end else begin
      rv2_q <= rv_q;
    end
  end

  assign rvalid = rv2_q;
  assign rdata  = out_q;
`else
  logic [NRP-1:0][DATA_W-1:0] rdata_a;

  always_comb begin
    rdata_a = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      rdata_a[p] = rv_q[p] ? rd_mux[p] : out_q[p];
    end
  end

  assign rvalid = rv_q;
  assign rdata  = rdata_a;
`endif

  logic [STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (stat_clr) begin
      stall_d = '0;
    end else if ((|(rreq & ~rgnt)) && (stall_q != STAT_SAT)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule
